// File: rtl/risc_pkg.sv
// ============================================================================
// Module : risc_pkg
// Brief  : Shared types, funct3 encodings and helpers for the load/store unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package risc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic mem_size_t f3_size(input logic [2:0] f3);
        if (f3[1])      return SZ_W;
        else if (f3[0]) return SZ_H;
        else            return SZ_B;
    endfunction

    // Unsigned variants only exist for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic we);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3_size(f3))
            SZ_H:    return addr_lo[0];
            SZ_W:    return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module : lsu_align
// Brief  : Combinational store byte-lane generation and load extract/extend.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_align
    import risc_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    mem_size_t   size;
    logic [1:0]  off;
    logic [31:0] shifted;

    always_comb begin
        size       = f3_size(funct3);
        off        = 2'b00;
        be         = 4'b1111;
        lane_wdata = store_data;
        // Low address bits below the access size are ignored, not trapped, here.
        case (size)
            SZ_B: begin
                off        = addr_lo;
                be         = 4'b0001 << off;
                lane_wdata = {4{store_data[7:0]}};
            end
            SZ_H: begin
                off        = {addr_lo[1], 1'b0};
                be         = 4'b0011 << off;
                lane_wdata = {2{store_data[15:0]}};
            end
            default: begin
                off        = 2'b00;
                be         = 4'b1111;
                lane_wdata = store_data;
            end
        endcase

        shifted   = load_word >> {off, 3'b000};
        load_data = shifted;
        case (size)
            SZ_B:    load_data = funct3[2] ? {24'd0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    load_data = funct3[2] ? {16'd0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module : load_store_unit
// Brief  : RV32I load/store unit with req/gnt/rvalid memory handshake,
//          core stall and register-file writeback. Optional macro
//          LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into errors.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import risc_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rf_wr_en,
    output logic [4:0]  rf_rd_addr,
    output logic [31:0] rf_wr_data,
    output logic        err
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    lsu_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;
    logic             we_q, err_q, wb_q;
    logic             accept, bad_req, timeout, timeout_hit, capture;
    logic [2:0]       sel_funct3;
    logic [1:0]       sel_addr_lo;
    logic [3:0]       be;
    logic [31:0]      lane_wdata, load_data;

    assign req_ready = (state == IDLE) && !reset;
    assign stall     = ((state == IDLE) && req_valid) || (state == REQ) || (state == WAIT);
    assign accept    = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    assign bad_req = !f3_legal(req_funct3, req_we) || f3_misaligned(req_funct3, req_addr[1:0]);
`else
    assign bad_req = !f3_legal(req_funct3, req_we);
`endif

    assign timeout     = (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign timeout_hit = timeout && (((state == REQ) && !mem_gnt) || ((state == WAIT) && !mem_rvalid));
    assign capture     = !we_q && mem_rvalid && (((state == REQ) && mem_gnt) || (state == WAIT));

    // Store lanes come from the live request; load extraction from the latched one.
    assign sel_funct3  = (state == IDLE) ? req_funct3    : funct3_q;
    assign sel_addr_lo = (state == IDLE) ? req_addr[1:0] : addr_lo_q;

    lsu_align u_align (
        .funct3     (sel_funct3),
        .addr_lo    (sel_addr_lo),
        .store_data (req_wdata),
        .load_word  (mem_rdata),
        .be         (be),
        .lane_wdata (lane_wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = bad_req ? DONE : REQ;
            REQ: begin
                if (mem_gnt) begin
                    if (we_q || mem_rvalid) state_nxt = DONE;
                    else                    state_nxt = WAIT;
                end else if (timeout) begin
                    state_nxt = DONE;
                end
            end
            WAIT:    if (mem_rvalid || timeout) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            funct3_q   <= 3'd0;
            addr_lo_q  <= 2'd0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            wb_q       <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_be     <= 4'd0;
            rf_rd_addr <= 5'd0;
            rf_wr_data <= 32'd0;
        end else begin
            if ((state_nxt != state) && ((state_nxt == REQ) || (state_nxt == WAIT)))
                cnt <= '0;
            else if ((state == REQ) || (state == WAIT))
                cnt <= cnt + CNT_W'(1);

            if (accept) begin
                funct3_q   <= req_funct3;
                addr_lo_q  <= req_addr[1:0];
                we_q       <= req_we;
                rf_rd_addr <= req_rd;
                err_q      <= bad_req;
                wb_q       <= 1'b0;
                if (!bad_req) begin
                    mem_req   <= 1'b1;
                    mem_we    <= req_we;
                    mem_addr  <= {req_addr[31:2], 2'b00};
                    mem_wdata <= lane_wdata;
                    mem_be    <= be;
                end
            end else begin
                if ((state == REQ) && (mem_gnt || timeout))
                    mem_req <= 1'b0;
                if (timeout_hit)
                    err_q <= 1'b1;
                if (capture) begin
                    rf_wr_data <= load_data;
                    wb_q       <= (rf_rd_addr != 5'd0);
                end
            end
        end
    end

    assign rf_wr_en = (state == DONE) && wb_q;
    assign err      = (state == DONE) && err_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module : tb_load_store_unit
// Brief  : Self-checking bench for load_store_unit against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_wr_en;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_wr_data;
    logic        err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rf_wr_en   (rf_wr_en),
        .rf_rd_addr (rf_rd_addr),
        .rf_wr_data (rf_wr_data),
        .err        (err)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: access size in bytes, lane offset, legality.
    function automatic int size_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'd2) return 4;
        if (f3[1:0] == 2'd1) return 2;
        return 1;
    endfunction

    function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
        int s = size_bytes(f3);
        return int'(a % 4) & ~(s - 1);
    endfunction

    function automatic bit is_bad(input logic we, input logic [2:0] f3, input logic [31:0] a);
        bit ok;
        ok = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef LSU_MISALIGN_TRAP_EN
        if (ok && ((a % size_bytes(f3)) != 0)) ok = 1'b0;
`endif
        return !ok;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] word);
        int          s = size_bytes(f3);
        logic [31:0] v, mask;
        v = word >> (8 * lane_off(f3, a));
        if (s < 4) begin
            mask = (32'd1 << (8 * s)) - 32'd1;
            v    = v & mask;
            if (!f3[2] && v[8*s-1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        int s = size_bytes(f3);
        if (s == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
        if (s == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int s = size_bytes(f3);
        return 4'(((1 << s) - 1) << lane_off(f3, a));
    endfunction

    // One full transaction; gnt arrives on REQ cycle gnt_dly (>=TO means never),
    // rvalid rv_dly cycles after gnt for loads.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd,
                           input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        bit bad, timed_out, exp_wr;
        int end_n;
        bad        = is_bad(we, f3, addr);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        #1;
        check_value("req_ready_idle", req_ready, 1);
        check_value("stall_accept", stall, 1);
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        if (bad) begin
            check_value("bad_mem_req", mem_req, 0);
            check_value("bad_err", err, 1);
            check_value("bad_rf_wr_en", rf_wr_en, 0);
            check_value("bad_stall", stall, 0);
        end else begin
            timed_out = (gnt_dly >= TO);
            end_n     = timed_out ? TO - 1 : (we ? gnt_dly : gnt_dly + rv_dly);
            for (int n = 0; n <= end_n; n++) begin
                mem_gnt    = (n == gnt_dly);
                mem_rvalid = !we && !timed_out && (n == gnt_dly + rv_dly);
                mem_rdata  = mem_rvalid ? rdata : $urandom;
                if (n == 0) begin
                    check_value("mem_addr", mem_addr, {addr[31:2], 2'b00});
                    check_value("mem_we", mem_we, we);
                    if (we) begin
                        check_value("mem_be", mem_be, model_be(f3, addr));
                        check_value("mem_wdata", mem_wdata, model_wdata(f3, wdata));
                    end
                end
                check_value("mem_req_busy", mem_req, n <= gnt_dly);
                check_value("stall_busy", stall, 1);
                check_value("rf_wr_en_busy", rf_wr_en, 0);
                check_value("err_busy", err, 0);
                @(posedge clk); #1;
            end
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            exp_wr     = !we && !timed_out && (rd != 5'd0);
            check_value("done_err", err, timed_out);
            check_value("done_rf_wr_en", rf_wr_en, exp_wr);
            check_value("done_mem_req", mem_req, 0);
            check_value("done_stall", stall, 0);
            if (exp_wr) begin
                check_value("rf_rd_addr", rf_rd_addr, rd);
                check_value("rf_wr_data", rf_wr_data, model_load(f3, addr, rdata));
            end
        end
        @(posedge clk); #1;
        // Stray rvalid while idle must be ignored.
        mem_rvalid = 1'($urandom % 2);
        mem_rdata  = $urandom;
        #1;
        check_value("idle_req_ready", req_ready, 1);
        check_value("idle_rf_wr_en", rf_wr_en, 0);
        check_value("idle_err", err, 0);
        @(posedge clk); #1;
        check_value("idle_rf_wr_en2", rf_wr_en, 0);
        mem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_rd     = 5'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        #12;
        check_value("rst_req_ready", req_ready, 0);
        check_value("rst_mem_req", mem_req, 0);
        check_value("rst_mem_be", mem_be, 0);
        check_value("rst_mem_addr", mem_addr, 0);
        check_value("rst_rf_wr_en", rf_wr_en, 0);
        check_value("rst_rf_wr_data", rf_wr_data, 0);
        check_value("rst_err", err, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_value("post_rst_ready", req_ready, 1);

        // Directed cases
        run_txn(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 0, 0, 32'hDEADBEEF);
        run_txn(1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 0, 0, 32'h80000000);
        run_txn(1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 0, 0, 32'h80000000);
        run_txn(1'b0, 3'b101, 32'h102, 32'h0, 5'd8, 0, 0, 32'h80000000);
        run_txn(1'b1, 3'b000, 32'h101, 32'h12345678, 5'd9, 0, 0, 32'h0);
        run_txn(1'b0, 3'b010, 32'h200, 32'h0, 5'd10, 3, 2, 32'hCAFEF00D);
        run_txn(1'b0, 3'b010, 32'h300, 32'h0, 5'd11, TO, 0, 32'h0);
        run_txn(1'b0, 3'b010, 32'h102, 32'h0, 5'd12, 0, 0, 32'hA5A55A5A);
        run_txn(1'b1, 3'b100, 32'h104, 32'h1, 5'd1, 0, 0, 32'h0);
        run_txn(1'b0, 3'b011, 32'h108, 32'h0, 5'd2, 0, 0, 32'h0);
        run_txn(1'b0, 3'b010, 32'h10C, 32'h0, 5'd0, 1, 1, 32'h11223344);

        // Reset in the middle of a load
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h400;
        req_rd     = 5'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_value("midrst_mem_req_before", mem_req, 1);
        #2 reset = 1'b1;
        #1;
        check_value("midrst_mem_req_async", mem_req, 0);
        check_value("midrst_req_ready", req_ready, 0);
        @(posedge clk); #1;
        reset      = 1'b0;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55AA55AA;
        #1;
        check_value("midrst_ready_after", req_ready, 1);
        check_value("midrst_no_wr", rf_wr_en, 0);
        @(posedge clk); #1;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        check_value("midrst_no_wr2", rf_wr_en, 0);
        check_value("midrst_no_err", err, 0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            int r, g;
            r = $urandom % 10;
            g = (r == 0) ? TO : (r % 4);
            run_txn(1'($urandom % 2), 3'($urandom % 8), $urandom, $urandom,
                    5'($urandom % 32), g, $urandom % 4, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
